// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge_if
//  Brief    : Bundles the command/response handshake and the APB bus of the
//             apb_master_bridge. "master" is the bridge view, "slave" is the
//             view of the requester plus the APB completer.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // command / response side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  // APB side
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge
//  Brief    : Converts single valid/ready commands into APB SETUP/ACCESS
//             transfers and returns a one-cycle response pulse.
//             Optional macro APB_MASTER_PREADY_EN enables pready/pslverr
//             wait-state support with a TIMEOUT-cycle watchdog; without it the
//             ACCESS phase always lasts one cycle and rsp_error is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic           pclk,
  input  wire logic           rst,
  apb_master_bridge_if.master bus
);

  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] c_ZERO_DATA = '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  logic   w_done;   // ACCESS ends on this cycle
  logic   w_tmo;    // ACCESS ends because the watchdog expired
  logic   w_err;    // error status to report if ACCESS ends now

`ifdef APB_MASTER_PREADY_EN
  // Counter holds the number of wait cycles already seen; the cycle on which
  // it equals TIMEOUT-1 with pready still low is the TIMEOUT-th wait cycle.
  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  assign w_tmo  = !bus.pready && (r_wait_cnt == c_CNT_LAST);
  assign w_done = bus.pready || w_tmo;
  assign w_err  = bus.pready ? bus.pslverr : 1'b1;
`else
  // Completer handshake is not used in this build.
  logic w_unused;
  assign w_unused = &{1'b0, bus.pready, bus.pslverr, (TIMEOUT > 0)};

  assign w_tmo  = 1'b0;
  assign w_done = 1'b1;
  assign w_err  = 1'b0;
`endif

  // Commands are only taken while no transfer is in flight.
  assign bus.req_ready = (r_state == S_IDLE);

  // Transfer sequencer: state, APB outputs and response registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= c_ZERO_ADDR;
      bus.pwdata    <= c_ZERO_DATA;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= c_ZERO_DATA;
      bus.rsp_error <= 1'b0;
`ifdef APB_MASTER_PREADY_EN
      r_wait_cnt    <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            // paddr/pwrite/pwdata double as the command capture registers
            bus.paddr   <= bus.req_addr;
            bus.pwrite  <= bus.req_write;
            bus.pwdata  <= bus.req_write ? bus.req_wdata : c_ZERO_DATA;
            bus.psel    <= 1'b1;
            bus.penable <= 1'b0;
            r_state     <= S_SETUP;
`ifdef APB_MASTER_PREADY_EN
            r_wait_cnt  <= '0;
`endif
          end
        end
        S_SETUP: begin
          bus.penable <= 1'b1;
          r_state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= w_err;
            bus.rsp_rdata <= (bus.pwrite || w_tmo) ? c_ZERO_DATA : bus.prdata;
            r_state       <= S_IDLE;
          end
`ifdef APB_MASTER_PREADY_EN
          else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge
//  Brief    : Directed/randomized bench for apb_master_bridge with a memory
//             model of the APB completer. Honours APB_MASTER_PREADY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic pclk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  logic [31:0] mem [256];

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Edge counter used to measure accept-to-accept spacing.
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One complete command. waits = pready-low ACCESS cycles offered by the
  // completer; err = pslverr on the ready cycle; hold keeps req_valid high
  // (with junk payload) while the transfer is in flight.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input int waits, input bit err, input bit hold, output int acc);
    int          exp_lat;
    bit          exp_err;
    bit          tmo;
    bit          rdy;
    logic [31:0] exp_rd;
    int          got;
    tmo = 1'b0;
`ifdef APB_MASTER_PREADY_EN
    tmo     = (waits >= TIMEOUT);
    exp_lat = tmo ? 2 + TIMEOUT : 3 + waits;
    exp_err = tmo ? 1'b1 : err;
`else
    exp_lat = 3;
    exp_err = 1'b0;
`endif
    exp_rd = (w || tmo) ? 32'h0 : mem[a];

    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    acc = cyc;
    got = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.rsp_valid === 1'b1) begin
        got = c;
        break;
      end
      // request side changes must not disturb the transfer in flight
      bus.req_valid = hold;
      bus.req_write = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = $urandom;
      chk("psel",    32'(bus.psel),    32'd1);
      chk("penable", 32'(bus.penable), (c >= 2) ? 32'd1 : 32'd0);
      chk("paddr",   32'(bus.paddr),   32'(a));
      chk("pwrite",  32'(bus.pwrite),  32'(w));
      chk("pwdata",  bus.pwdata,       w ? d : 32'h0);
      if (c >= 2) begin
`ifdef APB_MASTER_PREADY_EN
        rdy        = !tmo && ((c - 2) >= waits);
        bus.pready = rdy;
`else
        rdy        = 1'b1;
        bus.pready = 1'($urandom);
`endif
        bus.pslverr = rdy ? err : 1'($urandom);
        bus.prdata  = rdy ? mem[a] : $urandom;
      end else begin
        bus.pready  = 1'($urandom);
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;
      end
    end
    chk("latency", 32'(got), 32'(exp_lat));
    if (got > 0) begin
      chk("rsp_error",     32'(bus.rsp_error), 32'(exp_err));
      chk("rsp_rdata",     bus.rsp_rdata,      exp_rd);
      chk("psel_done",     32'(bus.psel),      32'd0);
      chk("penable_done",  32'(bus.penable),   32'd0);
      chk("req_ready_done",32'(bus.req_ready), 32'd1);
      chk("paddr_hold",    32'(bus.paddr),     32'(a));
      chk("pwrite_hold",   32'(bus.pwrite),    32'(w));
    end
    if (w && !tmo) mem[a] = d;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
  endtask

  initial begin
    int acc;
    int prev;
    bit w;
    int waits;
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    rst = 1'b1;
    step();
    step();

    // reset state
    chk("rst_psel",      32'(bus.psel),      32'd0);
    chk("rst_penable",   32'(bus.penable),   32'd0);
    chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
    chk("rst_paddr",     32'(bus.paddr),     32'd0);
    chk("rst_pwdata",    bus.pwdata,         32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    step();

    // write then read back the same location
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, acc);
    bus.req_valid = 1'b0;
    step();
    chk("rsp_pulse_once", 32'(bus.rsp_valid), 32'd0);
    xfer(1'b0, 8'h10, 32'h0, 0, 1'b0, 1'b0, acc);
    chk("readback_mem", mem[8'h10], 32'hDEADBEEF);
    bus.req_valid = 1'b0;
    step();

    // back-to-back with req_valid held high
    xfer(1'b1, 8'($urandom), $urandom, 0, 1'b0, 1'b1, prev);
    for (int i = 0; i < 3; i++) begin
      w = 1'($urandom);
      xfer(w, 8'($urandom_range(0, 7)), $urandom, 0, 1'b0, 1'b1, acc);
      chk("b2b_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end
    bus.req_valid = 1'b0;
    step();

    // three wait states with slave error on the ready cycle
    xfer(1'b0, 8'($urandom), 32'h0, 3, 1'b1, 1'b0, acc);
    // completer never ready
    xfer(1'b0, 8'h22, 32'h0, 100, 1'b0, 1'b0, acc);
    bus.req_valid = 1'b0;
    step();

    // randomized mix
    for (int i = 0; i < 8; i++) begin
      waits = $urandom_range(0, 4);
      xfer(1'($urandom), 8'($urandom_range(0, 15)), $urandom, waits,
           1'($urandom), 1'($urandom), acc);
      bus.req_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end
    bus.req_valid = 1'b0;
    step();

    // reset while in ACCESS
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h33;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("pre_rst_penable", 32'(bus.penable), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_psel",    32'(bus.psel),    32'd0);
    chk("arst_penable", 32'(bus.penable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    rst = 1'b0;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    xfer(1'b1, 8'h44, $urandom, 0, 1'b0, 1'b0, acc);
    bus.req_valid = 1'b0;
    xfer(1'b0, 8'h44, 32'h0, 1, 1'b0, 1'b0, acc);
    bus.req_valid = 1'b0;
    step();
    chk("final_idle_rsp", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS wait cycles (only with APB_MASTER_PREADY_EN).
REQ-004 SHALL have port pclk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  command present.
REQ-007 SHALL have port req_ready  out  1  bridge accepts command.
REQ-008 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  ADDR_W  command address.
REQ-010 SHALL have port req_wdata  in  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
REQ-013 SHALL have port rsp_error  out  1  slave error or timeout; valid with rsp_valid.
REQ-014 SHALL have APB ports paddr (out ADDR_W), psel (out 1), penable (out 1), pwrite (out 1), pwdata (out DATA_W), prdata (in DATA_W), pready (in 1), pslverr (in 1).

Function
REQ-015 SHALL implement states IDLE, SETUP, ACCESS.
REQ-016 SHALL drive req_ready=1 only in IDLE; a command is accepted when req_valid & req_ready.
REQ-017 SHALL register req_write/addr/wdata on acceptance and hold paddr/pwrite/pwdata stable from SETUP until the end of ACCESS.
REQ-018 IDLE->SETUP on acceptance; SETUP->ACCESS unconditionally after one cycle.
REQ-019 SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1; IDLE: psel=0, penable=0.
REQ-020 ACCESS completes on the cycle the transfer ends (REQ-029/030); next state IDLE.
REQ-021 On completion, rsp_valid SHALL be 1 for exactly the next cycle, with rsp_rdata = prdata sampled at completion (reads) or 0 (writes).
REQ-022 Command-accept-to-rsp_valid latency SHALL be 3 cycles with zero wait states; min back-to-back spacing 3 cycles between accepts.
REQ-023 pwdata SHALL be 0 for reads; paddr/pwrite SHALL retain their last values in IDLE.
REQ-024 req_valid dropping while not in IDLE SHALL have no effect on the transfer in flight.

Reset
REQ-025 rst SHALL asynchronously force state IDLE and psel, penable, pwrite, rsp_valid, rsp_error = 0; paddr, pwdata, rsp_rdata = 0.
REQ-026 rst asserted mid-transfer SHALL abort it with no rsp_valid pulse; req_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL use macro APB_MASTER_PREADY_EN to select wait-state support.
REQ-028 Without APB_MASTER_PREADY_EN: pready and pslverr SHALL be ignored; ACCESS SHALL last exactly one cycle; rsp_error is always 0.
REQ-029 With APB_MASTER_PREADY_EN: ACCESS SHALL complete on the first cycle with pready=1; rsp_error = pslverr sampled on that cycle.
REQ-030 With APB_MASTER_PREADY_EN: a wait counter SHALL count ACCESS cycles with pready=0. When it reaches TIMEOUT, the transfer SHALL be terminated with rsp_error=1 and rsp_rdata=0. The counter SHALL clear on entry to SETUP.

Verification
REQ-031 Write: req addr=0x10, wdata=0xDEADBEEF -> SETUP then ACCESS with paddr=0x10, pwrite=1, pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_error=0.
REQ-032 Read after write: read addr=0x10, slave returns 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_error=0.
REQ-033 Back-to-back: req_valid held high for 4 commands -> 4 accepts exactly 3 cycles apart; psel never glitches low within a transfer.
REQ-034 PREADY_EN: pready low for 3 ACCESS cycles with pslverr=1 on the ready cycle -> rsp_valid 6 cycles after accept, rsp_error=1.
REQ-035 PREADY_EN, TIMEOUT=16: pready stuck 0 -> rsp_valid with rsp_error=1 and rsp_rdata=0 after 16 wait cycles; bridge returns to IDLE.
REQ-036 Reset during ACCESS -> psel/penable=0 immediately (asynchronously), no rsp_valid, and the next command completes normally.
